bcg_timing: RTL and testbench
=============================

BCG_TIMING -- requirements
Module: bcg_timing

Interface
REQ-001 SHALL have parameter H_ACT, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16; H_SW, 96; H_BP, 48: horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACT, 480, visible lines.
REQ-004 SHALL have parameter V_FP, 10; V_SW, 2; V_BP, 33: vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameter LOOKAHEAD, 4, pixels by which cx/cy lead x/y; legal range 1..15.
REQ-006 SHALL have port clk, input, 1, single system clock at 2x pixel rate.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port x, output, 10, current pixel column.
REQ-009 SHALL have port y, output, 9, current line, low 9 bits of the vertical counter.
REQ-010 SHALL have port cx, output, 10, look-ahead column for the background fetcher.
REQ-011 SHALL have port cy, output, 9, line of the look-ahead position.
REQ-012 SHALL have port phase, output, 2, fetch-slot index for the 4-clock background fetch sequence.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-015 SHALL have port de, output, 1, display enable, high in the visible area.
REQ-016 SHALL have port frame, output, 1, one-clock pulse at frame start.

Function
REQ-017 SHALL hold internal registers sub (1 bit), hcnt (10 bits) and vcnt (10 bits); H_TOT = H_ACT+H_FP+H_SW+H_BP (800), V_TOT likewise (525).
REQ-018 SHALL toggle sub every clock; hcnt SHALL increment when sub=1, wrapping H_TOT-1 -> 0.
REQ-019 SHALL increment vcnt when hcnt wraps, wrapping V_TOT-1 -> 0; a frame is exactly 2*H_TOT*V_TOT clocks (840000).
REQ-020 SHALL register every output so that its value in a cycle decodes the (sub,hcnt,vcnt) held in that same cycle, with no combinational path from counters to ports.
REQ-021 SHALL drive x = hcnt and y = vcnt[8:0]; y aliases during vertical blanking, where de=0.
REQ-022 SHALL drive cx = hcnt+LOOKAHEAD and cy = vcnt[8:0] when hcnt+LOOKAHEAD < H_TOT.
REQ-023 SHALL otherwise drive cx = hcnt+LOOKAHEAD-H_TOT and cy = low 9 bits of (vcnt+1) mod V_TOT, using 11-bit intermediate sums.
REQ-024 SHALL drive phase = {hcnt[0], sub}, so phase=0 on the first clock of every even pixel and cycles 0,1,2,3 without gaps.
REQ-025 SHALL drive de = 1 iff hcnt < H_ACT and vcnt < V_ACT.
REQ-026 SHALL drive hsync = 0 iff H_ACT+H_FP <= hcnt < H_ACT+H_FP+H_SW (656..751).
REQ-027 SHALL drive vsync = 0 iff V_ACT+V_FP <= vcnt < V_ACT+V_FP+V_SW (490..491), across whole lines.
REQ-028 SHALL drive frame = 1 only when sub=0, hcnt=0 and vcnt=0.

Reset
REQ-029 SHALL, while rst=0, force sub=0, hcnt=0, vcnt=0 and outputs x=0, y=0, cx=LOOKAHEAD, cy=0, phase=0, hsync=1, vsync=1, de=1, frame=1.
REQ-030 SHALL, on the first rising clk edge after rst deasserts, advance to sub=1 (phase=1, frame=0), so timing restarts cleanly at frame start.
REQ-031 SHALL, on reset asserted mid-frame, return to the REQ-029 state immediately, independent of clk.

Verification
REQ-032 Release reset, run 840000 clocks -> frame high exactly once at clock 0, then again at clock 840000; phase sequence 0,1,2,3 repeats throughout.
REQ-033 hcnt=795..799 on vcnt=10 -> cx=799,0,1,2,3 with cy=10,11,11,11,11; x=795..799.
REQ-034 vcnt=524, hcnt=796 -> cx=0, cy=0; at vcnt=479, hcnt=796 -> cy=480 truncated to 9 bits (480).
REQ-035 Count per line -> de high for 1280 clocks; hsync low for 192 clocks, starting at hcnt=656; vsync low for exactly 2 lines (vcnt 490,491).
REQ-036 Assert rst for 3 clocks at vcnt=300, hcnt=400 -> outputs match REQ-029 within the reset window; next frame pulse appears 840000 clocks after release.
REQ-037 Rebuild with LOOKAHEAD=8 -> at hcnt=792, cx=0 and cy=vcnt+1; at hcnt=0, cx=8.

Source files
------------

// File: rtl/bcg_timing_if.sv
// Raster timing bundle: pixel/line position, look-ahead position, fetch phase and syncs.
interface bcg_timing_if;
  logic [9:0] x;
  logic [8:0] y;
  logic [9:0] cx;
  logic [8:0] cy;
  logic [1:0] phase;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       frame;

  modport master (
    output x, y, cx, cy, phase, hsync, vsync, de, frame
  );

  modport slave (
    input x, y, cx, cy, phase, hsync, vsync, de, frame
  );
endinterface

// File: rtl/bcg_timing.sv
// Video raster timing generator running at twice the pixel rate, with a look-ahead
// position and 4-slot fetch phase for the background fetcher.
module bcg_timing #(
  parameter int H_ACT     = 640,
  parameter int H_FP      = 16,
  parameter int H_SW      = 96,
  parameter int H_BP      = 48,
  parameter int V_ACT     = 480,
  parameter int V_FP      = 10,
  parameter int V_SW      = 2,
  parameter int V_BP      = 33,
  parameter int LOOKAHEAD = 4
) (
  input  logic              clk,
  input  logic              rst,
  bcg_timing_if.master      tim
);

  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;

  logic       sub;
  logic [9:0] hcnt;
  logic [9:0] vcnt;

  logic       sub_nxt;
  logic [9:0] hcnt_nxt;
  logic [9:0] vcnt_nxt;
  logic       h_wrap;
  logic [10:0] cx_sum;
  logic       la_wrap;
  logic [9:0] cx_nxt;
  logic [8:0] cy_nxt;
  logic       de_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       frame_nxt;

  always_comb begin
    sub_nxt  = ~sub;
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    h_wrap   = sub && (hcnt == 10'(H_TOT - 1));
    if (sub) begin
      hcnt_nxt = h_wrap ? '0 : hcnt + 10'd1;
    end
    if (h_wrap) begin
      vcnt_nxt = (vcnt == 10'(V_TOT - 1)) ? '0 : vcnt + 10'd1;
    end
  end

  // Outputs decode the next counter state so the registered ports line up
  // with the counters in the same cycle.
  always_comb begin
    cx_sum  = {1'b0, hcnt_nxt} + 11'(LOOKAHEAD);
    la_wrap = cx_sum >= 11'(H_TOT);
    cx_nxt  = la_wrap ? 10'(cx_sum - 11'(H_TOT)) : cx_sum[9:0];
    cy_nxt  = vcnt_nxt[8:0];
    if (la_wrap) begin
      cy_nxt = (vcnt_nxt == 10'(V_TOT - 1)) ? 9'd0 : 9'(vcnt_nxt + 10'd1);
    end
    de_nxt    = (hcnt_nxt < 10'(H_ACT)) && (vcnt_nxt < 10'(V_ACT));
    hsync_nxt = !((hcnt_nxt >= 10'(H_ACT + H_FP)) && (hcnt_nxt < 10'(H_ACT + H_FP + H_SW)));
    vsync_nxt = !((vcnt_nxt >= 10'(V_ACT + V_FP)) && (vcnt_nxt < 10'(V_ACT + V_FP + V_SW)));
    frame_nxt = !sub_nxt && (hcnt_nxt == '0) && (vcnt_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub       <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      tim.x     <= '0;
      tim.y     <= '0;
      tim.cx    <= 10'(LOOKAHEAD);
      tim.cy    <= '0;
      tim.phase <= '0;
      tim.hsync <= 1'b1;
      tim.vsync <= 1'b1;
      tim.de    <= 1'b1;
      tim.frame <= 1'b1;
    end else begin
      sub       <= sub_nxt;
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      tim.x     <= hcnt_nxt;
      tim.y     <= vcnt_nxt[8:0];
      tim.cx    <= cx_nxt;
      tim.cy    <= cy_nxt;
      tim.phase <= {hcnt_nxt[0], sub_nxt};
      tim.hsync <= hsync_nxt;
      tim.vsync <= vsync_nxt;
      tim.de    <= de_nxt;
      tim.frame <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_bcg_timing.sv
// Scoreboard bench for bcg_timing: a raster model derived from elapsed clocks predicts
// every output; three instances cover scaled timing, default timing and LOOKAHEAD=8.
module tb_bcg_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] cx;
    logic [8:0] cy;
    logic [1:0] phase;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame;
  } exp_t;

  // Small raster so whole frames fit in a short run: 32 x 17 -> 1088 clocks per frame
  localparam int A_HA = 16, A_HF = 4, A_HS = 6, A_HB = 6;
  localparam int A_VA = 10, A_VF = 2, A_VS = 2, A_VB = 3;
  localparam int A_FRAME = 2 * (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB);
  localparam int P1_CLOCKS = 20000;

  logic clk;
  logic rst;
  int   n;
  int   tests;
  int   fails;
  int   de_cnt, hs_cnt, hs_first, fr_cnt;
  bit   no_rst_yet;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  bcg_timing_if if_a ();
  bcg_timing_if if_b ();
  bcg_timing_if if_c ();

  bcg_timing #(
    .H_ACT(A_HA), .H_FP(A_HF), .H_SW(A_HS), .H_BP(A_HB),
    .V_ACT(A_VA), .V_FP(A_VF), .V_SW(A_VS), .V_BP(A_VB)
  ) dut_a (.clk(clk), .rst(rst), .tim(if_a.master));

  bcg_timing dut_b (.clk(clk), .rst(rst), .tim(if_b.master));

  bcg_timing #(.LOOKAHEAD(8)) dut_c (.clk(clk), .rst(rst), .tim(if_c.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position after n clocks is pure arithmetic on the frame length.
  function automatic exp_t model(int cnt, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb, int la);
    int ht, vt, t, h, v, c;
    exp_t e;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    t  = cnt % (2 * ht * vt);
    h  = (t / 2) % ht;
    v  = (t / 2) / ht;
    c  = h + la;
    e.x     = 10'(h);
    e.y     = 9'(v % 512);
    e.phase = 2'((h % 2) * 2 + (t % 2));
    if (c < ht) begin
      e.cx = 10'(c);
      e.cy = 9'(v % 512);
    end else begin
      e.cx = 10'(c - ht);
      e.cy = 9'(((v + 1) % vt) % 512);
    end
    e.de    = (h < ha) && (v < va);
    e.hsync = !((h >= ha + hf) && (h < ha + hf + hs));
    e.vsync = !((v >= va + vf) && (v < va + vf + vs));
    e.frame = (t == 0);
    return e;
  endfunction

  function automatic exp_t exp_a(int cnt);
    return model(cnt, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 4);
  endfunction
  function automatic exp_t exp_b(int cnt);
    return model(cnt, 640, 16, 96, 48, 480, 10, 2, 33, 4);
  endfunction
  function automatic exp_t exp_c(int cnt);
    return model(cnt, 640, 16, 96, 48, 480, 10, 2, 33, 8);
  endfunction

  function automatic exp_t act_a();
    return {if_a.x, if_a.y, if_a.cx, if_a.cy, if_a.phase, if_a.hsync, if_a.vsync, if_a.de, if_a.frame};
  endfunction
  function automatic exp_t act_b();
    return {if_b.x, if_b.y, if_b.cx, if_b.cy, if_b.phase, if_b.hsync, if_b.vsync, if_b.de, if_b.frame};
  endfunction
  function automatic exp_t act_c();
    return {if_c.x, if_c.y, if_c.cx, if_c.cy, if_c.phase, if_c.hsync, if_c.vsync, if_c.de, if_c.frame};
  endfunction

  task automatic check(string name, exp_t act, exp_t ex);
    tests++;
    if (act !== ex) begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s n=%0d got x=%0d y=%0d cx=%0d cy=%0d ph=%0d hs=%0b vs=%0b de=%0b fr=%0b want x=%0d y=%0d cx=%0d cy=%0d ph=%0d hs=%0b vs=%0b de=%0b fr=%0b",
                 name, n, act.x, act.y, act.cx, act.cy, act.phase, act.hsync, act.vsync, act.de, act.frame,
                 ex.x, ex.y, ex.cx, ex.cy, ex.phase, ex.hsync, ex.vsync, ex.de, ex.frame);
    end
  endtask

  task automatic check_int(string name, int act, int ex);
    tests++;
    if (act != ex) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, ex);
    end
  endtask

  // Stimulus side of the scoreboard: one expectation per clock per instance.
  always @(posedge clk) begin
    if (!rst) n = 0;
    else      n = n + 1;
    q_a.push_back(exp_a(n));
    q_b.push_back(exp_b(n));
    q_c.push_back(exp_c(n));
  end

  always @(negedge clk) begin
    if (q_a.size() > 0) check("dut_a", act_a(), q_a.pop_front());
    if (q_b.size() > 0) check("dut_b", act_b(), q_b.pop_front());
    if (q_c.size() > 0) check("dut_c_la8", act_c(), q_c.pop_front());
    if (no_rst_yet && rst) begin
      if (n >= 1600 && n < 3200) begin
        if (if_b.de) de_cnt++;
        if (!if_b.hsync) begin
          if (hs_cnt == 0) hs_first = int'(if_b.x);
          hs_cnt++;
        end
      end
      if (n >= 1 && n <= P1_CLOCKS && if_a.frame) fr_cnt++;
    end
  end

  initial begin
    int wait_clks, hold_clks;
    tests = 0; fails = 0; n = 0;
    de_cnt = 0; hs_cnt = 0; hs_first = -1; fr_cnt = 0;
    no_rst_yet = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (P1_CLOCKS) @(negedge clk);
    #1;
    check_int("de_clocks_per_line", de_cnt, 2 * 640);
    check_int("hsync_low_clocks", hs_cnt, 2 * 96);
    check_int("hsync_start_x", hs_first, 656);
    check_int("frame_pulses", fr_cnt, P1_CLOCKS / A_FRAME);

    for (int k = 0; k < 8; k++) begin
      wait_clks = int'($urandom_range(50, 3000));
      hold_clks = int'($urandom_range(1, 4));
      repeat (wait_clks) @(negedge clk);
      #2;
      no_rst_yet = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_async_a", act_a(), exp_a(0));
      check("rst_async_b", act_b(), exp_b(0));
      check("rst_async_c", act_c(), exp_c(0));
      repeat (hold_clks) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
    end
    repeat (A_FRAME + 1500) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
